mem_arbiter: RTL and testbench

- Arbitrates the processor's single-port instruction/data RAM between two requesters: the fetch unit and the load/store unit.
- Sits between the core and the RAM instance; it is the only master of the RAM port.
- Sequences each access: latch request, issue one RAM cycle, wait the RAM latency, return a one-cycle response.
- Data port has priority. A starvation guard forces a fetch grant after STARVE_LIMIT consecutive data wins.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_if.sv | 50 +++++
 rtl/mem_arb_prio.sv | 40 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } req_id_t;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, load/store and RAM-port signals seen by the arbiter.
interface mem_arb_if #(
  parameter int unsigned ADDR_W = 16
);
  import mem_arb_pkg::*;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic              if_rsp_err;
  logic [WORD_W-1:0] if_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [WORD_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_err, if_rdata,
    input  d_req_valid, d_we, d_be, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Core and RAM side
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_err, if_rdata,
    output d_req_valid, d_we, d_be, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data with a starvation guard for fetch.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    if_valid,
  input  logic    d_valid,
  input  logic    handshake,
  input  req_id_t winner,
  output logic    grant_fetch,
  output logic    grant_data
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] starve_cnt;
  logic             data_first;

  // Data wins unless fetch has lost STARVE_LIMIT times in a row
  assign data_first  = d_valid && (starve_cnt < CNT_W'(STARVE_LIMIT));
  assign grant_data  = data_first || (d_valid && !if_valid);
  assign grant_fetch = if_valid && !data_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (handshake) begin
      if (winner == REQ_DATA && if_valid) begin
        if (starve_cnt >= CNT_W'(STARVE_LIMIT)) starve_cnt <= CNT_W'(STARVE_LIMIT);
        else                                    starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: accepts one fetch or load/store at a time,
// issues one RAM cycle, waits the RAM latency and returns a one-cycle response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.slave  bus
);

  localparam int unsigned LAT_W = 3;

  state_t           state;
  req_id_t          req_id;
  logic             req_store;
  logic [LAT_W-1:0] lat_cnt;

  logic grant_fetch;
  logic grant_data;
  logic idle;
  logic hs_fetch;
  logic hs_data;
  logic misaligned;
  logic unused_addr_bits;

  assign idle              = (state == IDLE) && !reset;
  assign bus.if_req_ready  = idle && grant_fetch;
  assign bus.d_req_ready   = idle && grant_data;
  assign hs_fetch          = bus.if_req_ready && bus.if_req_valid;
  assign hs_data           = bus.d_req_ready && bus.d_req_valid;
  assign misaligned        = bus.if_addr[1:0] != 2'b00;
  assign unused_addr_bits  = ^bus.d_addr[1:0];

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (bus.if_req_valid),
    .d_valid     (bus.d_req_valid),
    .handshake   (hs_fetch || hs_data),
    .winner      (hs_data ? REQ_DATA : REQ_FETCH),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  // RAM strobe and responses are pulses; every cycle defaults them to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      req_id           <= REQ_FETCH;
      req_store        <= 1'b0;
      lat_cnt          <= '0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_be       <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_err   <= 1'b0;
      bus.if_rdata     <= '0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rdata      <= '0;
    end else begin
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_be       <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_err   <= 1'b0;
      bus.if_rdata     <= '0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rdata      <= '0;

      case (state)
        IDLE: begin
          if (hs_fetch || hs_data) begin
            req_id    <= hs_data ? REQ_DATA : REQ_FETCH;
            req_store <= hs_data && bus.d_we;
            if (hs_fetch && misaligned) begin
              bus.if_rsp_valid <= 1'b1;
              bus.if_rsp_err   <= 1'b1;
              state            <= RESP;
            end else begin
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= hs_data && bus.d_we;
              bus.mem_be    <= hs_data ? bus.d_be : {BE_W{1'b1}};
              bus.mem_addr  <= hs_data ? bus.d_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
              bus.mem_wdata <= hs_data ? bus.d_wdata : '0;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_W'(MEM_LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (req_id == REQ_FETCH) begin
              bus.if_rsp_valid <= 1'b1;
              bus.if_rdata     <= bus.mem_rdata;
            end else begin
              bus.d_rsp_valid  <= 1'b1;
              bus.d_rdata      <= req_store ? '0 : bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LATENCY=1 and one with
// MEM_LATENCY=3 share a behavioural RAM; sel picks which one is exercised.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic sel;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              d_req_valid;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;

  logic              o_if_ready, o_d_ready, o_if_rsp_valid, o_if_rsp_err, o_d_rsp_valid;
  logic [31:0]       o_if_rdata, o_d_rdata, o_mem_wdata;
  logic              o_mem_en, o_mem_we;
  logic [3:0]        o_mem_be;
  logic [ADDR_W-3:0] o_mem_addr;

  logic [31:0]       ram [0:16383];
  logic [31:0]       rd_pipe [0:2];
  logic              pl_en;
  logic [13:0]       pl_idx;
  logic [31:0]       pl_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  bit   gq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(ADDR_W)) b1 ();
  mem_arb_if #(.ADDR_W(ADDR_W)) b3 ();

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk (clk), .reset (reset), .bus (b1.slave)
  );
  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk (clk), .reset (reset), .bus (b3.slave)
  );

  assign b1.if_req_valid = if_req_valid & ~sel;
  assign b1.if_addr      = if_addr;
  assign b1.d_req_valid  = d_req_valid & ~sel;
  assign b1.d_we         = d_we;
  assign b1.d_be         = d_be;
  assign b1.d_addr       = d_addr;
  assign b1.d_wdata      = d_wdata;
  assign b1.mem_rdata    = rd_pipe[0];

  assign b3.if_req_valid = if_req_valid & sel;
  assign b3.if_addr      = if_addr;
  assign b3.d_req_valid  = d_req_valid & sel;
  assign b3.d_we         = d_we;
  assign b3.d_be         = d_be;
  assign b3.d_addr       = d_addr;
  assign b3.d_wdata      = d_wdata;
  assign b3.mem_rdata    = rd_pipe[2];

  assign o_if_ready     = sel ? b3.if_req_ready : b1.if_req_ready;
  assign o_d_ready      = sel ? b3.d_req_ready  : b1.d_req_ready;
  assign o_if_rsp_valid = sel ? b3.if_rsp_valid : b1.if_rsp_valid;
  assign o_if_rsp_err   = sel ? b3.if_rsp_err   : b1.if_rsp_err;
  assign o_if_rdata     = sel ? b3.if_rdata     : b1.if_rdata;
  assign o_d_rsp_valid  = sel ? b3.d_rsp_valid  : b1.d_rsp_valid;
  assign o_d_rdata      = sel ? b3.d_rdata      : b1.d_rdata;
  assign o_mem_en       = sel ? b3.mem_en       : b1.mem_en;
  assign o_mem_we       = sel ? b3.mem_we       : b1.mem_we;
  assign o_mem_be       = sel ? b3.mem_be       : b1.mem_be;
  assign o_mem_addr     = sel ? b3.mem_addr     : b1.mem_addr;
  assign o_mem_wdata    = sel ? b3.mem_wdata    : b1.mem_wdata;

  // RAM model: read data appears one cycle after mem_en, then ages down the pipe
  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    if (o_mem_en && o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= o_mem_en ? ram[o_mem_addr] : 32'hDEAD_BEEF;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One request: wait for its ready, check the RAM cycle, readies while busy,
  // response latency and the scoreboarded response payload.
  task automatic run_req(input bit is_d, input bit we, input logic [3:0] be,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit exp_err,
                         input int lat, input string tag);
    int   n;
    bit   got;
    exp_t e;
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    #1;
    n = 0;
    while (((is_d ? o_d_ready : o_if_ready) !== 1'b1) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_ready"}, 32'(n < 20), 32'd1);
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    got = 1'b0;
    for (int c = 1; c <= lat + 4 && n < 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_mem_en"}, 32'(o_mem_en), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) begin
          chk({tag, "_mem_addr"}, 32'(o_mem_addr), 32'(addr[ADDR_W-1:2]));
          chk({tag, "_mem_we"}, 32'(o_mem_we), 32'(we));
          chk({tag, "_mem_be"}, 32'(o_mem_be), is_d ? 32'(be) : 32'h0000_000F);
          if (is_d && we) chk({tag, "_mem_wdata"}, o_mem_wdata, wdata);
        end
      end else begin
        chk({tag, "_mem_en_pulse"}, 32'(o_mem_en), 32'd0);
      end
      chk({tag, "_busy_ready"}, 32'(o_if_ready | o_d_ready), 32'd0);
      if ((is_d ? o_d_rsp_valid : o_if_rsp_valid) === 1'b1) begin
        got = 1'b1;
        chk({tag, "_latency"}, 32'(c), 32'(lat));
        e = sb.pop_front();
        chk({tag, "_rdata"}, is_d ? o_d_rdata : o_if_rdata, e.rdata);
        if (!is_d) chk({tag, "_err"}, 32'(o_if_rsp_err), 32'(e.err));
        break;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got && sb.size() > 0) void'(sb.pop_front());
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; sel = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    preload(14'h0010, 32'hE3A0_0001);
    preload(14'h0040, 32'h1122_3344);
    chk("reset_flags", 32'({o_if_ready, o_d_ready, o_if_rsp_valid, o_if_rsp_err,
                            o_d_rsp_valid, o_mem_en, o_mem_we, o_mem_be}), 32'd0);
    chk("reset_rdata", o_if_rdata | o_d_rdata | o_mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_req(1'b0, 1'b0, 4'hF,    16'h0040, 32'h0,          32'hE3A0_0001, 1'b0, 3, "fetch");
    run_req(1'b1, 1'b1, 4'b0011, 16'h0100, 32'hAABB_CCDD,  32'h0,         1'b0, 3, "store");
    run_req(1'b1, 1'b0, 4'hF,    16'h0103, 32'h0,          32'h1122_CCDD, 1'b0, 3, "load");
    run_req(1'b0, 1'b0, 4'hF,    16'h0042, 32'h0,          32'h0,         1'b1, 1, "misaligned");

    // Both requesters valid continuously: expect D D D D F D D D D F
    gq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 16'h0300;
    d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 16'h0200;
    n = 0;
    while (gq.size() > 0 && n < 200) begin
      #1;
      if (o_if_ready || o_d_ready) begin
        chk("one_ready", 32'(o_if_ready & o_d_ready), 32'd0);
        chk("grant_order", 32'(o_d_ready), 32'(gq.pop_front()));
      end
      @(negedge clk);
      n++;
    end
    chk("grant_seq_done", 32'(gq.size()), 32'd0);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during the WAIT cycle of a load drops the response
    d_req_valid = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 16'h0100;
    #1;
    chk("rst_case_ready", 32'(o_d_ready), 32'd1);
    @(negedge clk);
    d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_flags", 32'({o_if_ready, o_d_ready, o_if_rsp_valid, o_if_rsp_err,
                              o_d_rsp_valid, o_mem_en, o_mem_we, o_mem_be}), 32'd0);
    chk("rst_mid_rdata", o_if_rdata | o_d_rdata | o_mem_wdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(o_d_rsp_valid | o_if_rsp_valid), 32'd0);
    end
    run_req(1'b0, 1'b0, 4'hF, 16'h0040, 32'h0, 32'hE3A0_0001, 1'b0, 3, "post_rst_fetch");

    // Three-cycle RAM latency instance
    @(negedge clk);
    sel = 1'b1;
    run_req(1'b1, 1'b0, 4'hF, 16'h0100, 32'h0, 32'h1122_CCDD, 1'b0, 5, "lat3_load");
    run_req(1'b0, 1'b0, 4'hF, 16'h0040, 32'h0, 32'hE3A0_0001, 1'b0, 5, "lat3_fetch");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
